// File: rtl/buffer_sched.sv
`default_nettype none
// ============================================================================
// Module   : buffer_sched
// Purpose  : Two-requester scheduler feeding a DEPTH-stage 2-bit symbol delay
//            pipeline. Bounded-burst round-robin arbitration, reserved-symbol
//            (2'b01) sanitising, per-requester in-flight occupancy counters.
// Ports    : clk                    - clock, all state on rising edge
//            rst_n                  - asynchronous active-low reset
//            i_flush                - synchronous pipeline clear, no grant
//            i_req0 / i_req1        - requests
//            i_in0  / i_in1         - 2-bit symbols, valid with matching req
//            o_gnt0 / o_gnt1        - combinational grants (one-hot or zero)
//            o_out                  - tail-stage symbol
//            o_out_valid            - tail stage holds an accepted symbol
//            o_out_owner            - owner of the tail symbol
//            o_sym_err              - pulses the cycle after a reserved
//                                     symbol is accepted
//            o_inflight0/1          - valid stages owned by requester 0 / 1
// Revision : 1.0 - initial release
// ============================================================================
module buffer_sched #(
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_req0,
  input  logic                         i_req1,
  input  logic [1:0]                   i_in0,
  input  logic [1:0]                   i_in1,
  output logic                         o_gnt0,
  output logic                         o_gnt1,
  output logic [1:0]                   o_out,
  output logic                         o_out_valid,
  output logic                         o_out_owner,
  output logic                         o_sym_err,
  output logic [$clog2(DEPTH+1)-1:0]   o_inflight0,
  output logic [$clog2(DEPTH+1)-1:0]   o_inflight1
);

  localparam int c_cnt_w   = $clog2(DEPTH + 1);
  localparam int c_burst_w = $clog2(MAX_BURST + 1);
  localparam logic [c_burst_w-1:0] c_max_burst = c_burst_w'(MAX_BURST);

  // Arbitration state
  logic                 r_last;
  logic [c_burst_w-1:0] r_burst;

  // Pipeline: index 0 is the head, DEPTH-1 the tail
  logic [DEPTH-1:0]       r_vld;
  logic [DEPTH-1:0]       r_own;
  logic [DEPTH-1:0][1:0]  r_dat;

  logic                 r_sym_err;
  logic [c_cnt_w-1:0]   r_inf0;
  logic [c_cnt_w-1:0]   r_inf1;

  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_pick1;
  logic       w_grant;
  logic [1:0] w_sym;
  logic [1:0] w_san;
  logic       w_dec0;
  logic       w_dec1;

  // Grants depend only on requests, flush and arbitration state.
  // During contention the current owner keeps the grant only while a burst is
  // actually in progress (1..MAX_BURST-1). burst==0 exists only after reset;
  // together with last=1 it hands the first contention to requester 0.
  always_comb begin
    w_gnt0  = 1'b0;
    w_gnt1  = 1'b0;
    w_pick1 = 1'b0;
    if (!i_flush) begin
      if (i_req0 && i_req1) begin
        if ((r_burst != '0) && (r_burst < c_max_burst)) begin
          w_pick1 = r_last;
        end else begin
          w_pick1 = ~r_last;
        end
        w_gnt0 = ~w_pick1;
        w_gnt1 = w_pick1;
      end else begin
        w_gnt0 = i_req0;
        w_gnt1 = i_req1;
      end
    end
  end

  assign w_grant = w_gnt0 | w_gnt1;
  assign w_sym   = w_gnt1 ? i_in1 : i_in0;
  // Reserved 01 collapses to 00; idle head slots also carry 00.
  assign w_san   = (!w_grant || (w_sym == 2'b01)) ? 2'b00 : w_sym;

  // A valid tail symbol leaves the pipeline on every edge.
  assign w_dec0  = r_vld[DEPTH-1] & ~r_own[DEPTH-1];
  assign w_dec1  = r_vld[DEPTH-1] &  r_own[DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last    <= 1'b1;
      r_burst   <= '0;
      r_vld     <= '0;
      r_own     <= '0;
      r_dat     <= '0;
      r_sym_err <= 1'b0;
      r_inf0    <= '0;
      r_inf1    <= '0;
    end else begin
      // Arbitration state only moves on a grant (flush implies no grant).
      if (w_grant) begin
        if (w_gnt1 == r_last) begin
          if (r_burst < c_max_burst) begin
            r_burst <= r_burst + c_burst_w'(1);
          end
        end else begin
          r_last  <= w_gnt1;
          r_burst <= c_burst_w'(1);
        end
      end

      r_sym_err <= w_grant && (w_sym == 2'b01);

      if (i_flush) begin
        r_vld  <= '0;
        r_own  <= '0;
        r_dat  <= '0;
        r_inf0 <= '0;
        r_inf1 <= '0;
      end else begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          r_vld[i] <= r_vld[i-1];
          r_own[i] <= r_own[i-1];
          r_dat[i] <= r_dat[i-1];
        end
        r_vld[0] <= w_grant;
        r_own[0] <= w_gnt1;
        r_dat[0] <= w_san;

        if (w_gnt0 && !w_dec0) begin
          r_inf0 <= r_inf0 + c_cnt_w'(1);
        end else if (!w_gnt0 && w_dec0) begin
          r_inf0 <= r_inf0 - c_cnt_w'(1);
        end

        if (w_gnt1 && !w_dec1) begin
          r_inf1 <= r_inf1 + c_cnt_w'(1);
        end else if (!w_gnt1 && w_dec1) begin
          r_inf1 <= r_inf1 - c_cnt_w'(1);
        end
      end
    end
  end

  assign o_gnt0      = w_gnt0;
  assign o_gnt1      = w_gnt1;
  assign o_out       = r_dat[DEPTH-1];
  assign o_out_valid = r_vld[DEPTH-1];
  assign o_out_owner = r_own[DEPTH-1];
  assign o_sym_err   = r_sym_err;
  assign o_inflight0 = r_inf0;
  assign o_inflight1 = r_inf1;

endmodule
`default_nettype wire

// File: tb/tb_buffer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_buffer_sched
// Purpose  : Directed self-checking bench for buffer_sched (DEPTH=4,
//            MAX_BURST=2). Expected values are hand-derived per scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buffer_sched;

  logic       clk;
  logic       rst_n;
  logic       i_flush;
  logic       i_req0;
  logic       i_req1;
  logic [1:0] i_in0;
  logic [1:0] i_in1;
  logic       o_gnt0;
  logic       o_gnt1;
  logic [1:0] o_out;
  logic       o_out_valid;
  logic       o_out_owner;
  logic       o_sym_err;
  logic [2:0] o_inflight0;
  logic [2:0] o_inflight1;

  int n_checks;
  int n_errors;

  buffer_sched #(.DEPTH(4), .MAX_BURST(2)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (i_flush),
    .i_req0      (i_req0),
    .i_req1      (i_req1),
    .i_in0       (i_in0),
    .i_in1       (i_in1),
    .o_gnt0      (o_gnt0),
    .o_gnt1      (o_gnt1),
    .o_out       (o_out),
    .o_out_valid (o_out_valid),
    .o_out_owner (o_out_owner),
    .o_sym_err   (o_sym_err),
    .o_inflight0 (o_inflight0),
    .o_inflight1 (o_inflight1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves time at posedge+1 with reset released.
  task automatic do_reset();
    rst_n   = 1'b0;
    i_flush = 1'b0;
    i_req0  = 1'b0;
    i_req1  = 1'b0;
    i_in0   = 2'b00;
    i_in1   = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Each cycle: set inputs, #1 settle, compare, then advance to posedge+1.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_flush = 1'b0; i_req0 = 1'b0; i_req1 = 1'b0; i_in0 = 2'b00; i_in1 = 2'b00;
    #2;
    n_checks++;
    if ({o_out_valid, o_out, o_out_owner, o_sym_err, o_inflight0, o_inflight1} !== 11'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got v=%b out=%b own=%b err=%b inf0=%0d inf1=%0d, expected all 0",
               o_out_valid, o_out, o_out_owner, o_sym_err, o_inflight0, o_inflight1);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_checks++;
      if ({o_gnt0, o_gnt1, o_out_valid, o_out, o_out_owner, o_sym_err, o_inflight0, o_inflight1} !== 13'd0) begin
        n_errors++;
        $display("FAIL idle cycle %0d: got g0=%b g1=%b v=%b out=%b own=%b err=%b inf0=%0d inf1=%0d, expected all 0",
                 c, o_gnt0, o_gnt1, o_out_valid, o_out, o_out_owner, o_sym_err, o_inflight0, o_inflight1);
      end
      next_cycle();
    end
  endtask

  task automatic test_latency_sanitise();
    logic [1:0] syms [4];
    logic [1:0] exp_out [4];
    logic [2:0] exp_inf0 [10];
    syms     = '{2'b11, 2'b10, 2'b01, 2'b00};
    exp_out  = '{2'b11, 2'b10, 2'b00, 2'b00};
    exp_inf0 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      i_req0 = (c < 4);
      i_in0  = (c < 4) ? syms[c] : 2'b00;
      #1;
      n_checks++;
      if (o_gnt0 !== (c < 4) || o_gnt1 !== 1'b0) begin
        n_errors++;
        $display("FAIL lat_gnt cycle %0d: got g0=%b g1=%b, expected g0=%b g1=0", c, o_gnt0, o_gnt1, (c < 4));
      end
      n_checks++;
      if (c >= 4 && c < 8) begin
        if (o_out_valid !== 1'b1 || o_out_owner !== 1'b0 || o_out !== exp_out[c-4]) begin
          n_errors++;
          $display("FAIL lat_out cycle %0d: got v=%b own=%b out=%b, expected v=1 own=0 out=%b",
                   c, o_out_valid, o_out_owner, o_out, exp_out[c-4]);
        end
      end else if (o_out_valid !== 1'b0 || o_out !== 2'b00 || o_out_owner !== 1'b0) begin
        n_errors++;
        $display("FAIL lat_idle cycle %0d: got v=%b own=%b out=%b, expected v=0 own=0 out=00",
                 c, o_out_valid, o_out_owner, o_out);
      end
      n_checks++;
      if (o_sym_err !== (c == 3)) begin
        n_errors++;
        $display("FAIL sym_err cycle %0d: got %b, expected %b", c, o_sym_err, (c == 3));
      end
      n_checks++;
      if (o_inflight0 !== exp_inf0[c] || o_inflight1 !== 3'd0) begin
        n_errors++;
        $display("FAIL lat_inflight cycle %0d: got inf0=%0d inf1=%0d, expected inf0=%0d inf1=0",
                 c, o_inflight0, o_inflight1, exp_inf0[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_burst_rr();
    logic exp_g1;
    logic exp_own;
    do_reset();
    i_req0 = 1'b1; i_req1 = 1'b1; i_in0 = 2'b10; i_in1 = 2'b11;
    for (int c = 0; c < 12; c++) begin
      // Grant pattern 0,0,1,1,0,0,1,1,...
      exp_g1 = ((c / 2) % 2) == 1;
      #1;
      n_checks++;
      if (o_gnt1 !== exp_g1 || o_gnt0 !== !exp_g1) begin
        n_errors++;
        $display("FAIL burst_gnt cycle %0d: got g0=%b g1=%b, expected g0=%b g1=%b",
                 c, o_gnt0, o_gnt1, !exp_g1, exp_g1);
      end
      if (c >= 4) begin
        exp_own = (((c - 4) / 2) % 2) == 1;
        n_checks++;
        if (o_out_valid !== 1'b1 || o_out_owner !== exp_own || o_out !== (exp_own ? 2'b11 : 2'b10)) begin
          n_errors++;
          $display("FAIL burst_out cycle %0d: got v=%b own=%b out=%b, expected v=1 own=%b out=%b",
                   c, o_out_valid, o_out_owner, o_out, exp_own, (exp_own ? 2'b11 : 2'b10));
        end
        n_checks++;
        if (o_inflight0 !== 3'd2 || o_inflight1 !== 3'd2) begin
          n_errors++;
          $display("FAIL burst_inflight cycle %0d: got inf0=%0d inf1=%0d, expected 2 and 2",
                   c, o_inflight0, o_inflight1);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_single_requester();
    logic exp_g1;
    do_reset();
    i_req1 = 1'b1; i_in1 = 2'b10;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (o_gnt1 !== 1'b1 || o_gnt0 !== 1'b0) begin
        n_errors++;
        $display("FAIL single_gnt cycle %0d: got g0=%b g1=%b, expected g0=0 g1=1", c, o_gnt0, o_gnt1);
      end
      next_cycle();
    end
    // req1 has saturated its burst, so contention hands over to req0 at once.
    i_req0 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      exp_g1 = (c >= 2);
      #1;
      n_checks++;
      if (o_gnt1 !== exp_g1 || o_gnt0 !== !exp_g1) begin
        n_errors++;
        $display("FAIL single_contend cycle %0d: got g0=%b g1=%b, expected g0=%b g1=%b",
                 c, o_gnt0, o_gnt1, !exp_g1, exp_g1);
      end
      next_cycle();
    end
    i_req0 = 1'b0; i_req1 = 1'b0;
  endtask

  task automatic test_flush();
    // Expected grant owner per cycle: 0,0,1,1,0,(flush),0,1,1,0,0
    logic exp_g1 [11];
    logic exp_any [11];
    exp_g1  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_any = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    i_req0 = 1'b1; i_req1 = 1'b1; i_in0 = 2'b10; i_in1 = 2'b11;
    for (int c = 0; c < 11; c++) begin
      i_flush = (c == 5);
      #1;
      n_checks++;
      if (o_gnt1 !== (exp_any[c] & exp_g1[c]) || o_gnt0 !== (exp_any[c] & !exp_g1[c])) begin
        n_errors++;
        $display("FAIL flush_gnt cycle %0d: got g0=%b g1=%b, expected g0=%b g1=%b",
                 c, o_gnt0, o_gnt1, exp_any[c] & !exp_g1[c], exp_any[c] & exp_g1[c]);
      end
      if (c >= 6 && c <= 9) begin
        n_checks++;
        if (o_out_valid !== 1'b0 || o_out !== 2'b00) begin
          n_errors++;
          $display("FAIL flush_outvalid cycle %0d: got v=%b out=%b, expected v=0 out=00", c, o_out_valid, o_out);
        end
      end
      if (c == 6) begin
        n_checks++;
        if (o_inflight0 !== 3'd0 || o_inflight1 !== 3'd0) begin
          n_errors++;
          $display("FAIL flush_inflight: got inf0=%0d inf1=%0d, expected 0 and 0", o_inflight0, o_inflight1);
        end
      end
      if (c == 10) begin
        n_checks++;
        if (o_out_valid !== 1'b1 || o_out_owner !== 1'b0 || o_out !== 2'b10) begin
          n_errors++;
          $display("FAIL flush_resume: got v=%b own=%b out=%b, expected v=1 own=0 out=10",
                   o_out_valid, o_out_owner, o_out);
        end
      end
      next_cycle();
    end
    i_flush = 1'b0; i_req0 = 1'b0; i_req1 = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    i_in0 = 2'b11;
    for (int c = 0; c < 5; c++) begin
      i_req0 = (c < 4);
      if (c < 4) next_cycle();
    end
    // Cycle 4 idle, advance into cycle 5: 3 symbols in flight, tail valid.
    next_cycle();
    #1;
    n_checks++;
    if (o_out_valid !== 1'b1 || o_inflight0 !== 3'd3) begin
      n_errors++;
      $display("FAIL areset_pre: got v=%b inf0=%0d, expected v=1 inf0=3", o_out_valid, o_inflight0);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_out_valid !== 1'b0 || o_out !== 2'b00 || o_inflight0 !== 3'd0 || o_sym_err !== 1'b0) begin
      n_errors++;
      $display("FAIL areset_clear: got v=%b out=%b inf0=%0d err=%b, expected all 0",
               o_out_valid, o_out, o_inflight0, o_sym_err);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_checks++;
      if (o_out_valid !== 1'b0 || o_out !== 2'b00 || o_inflight0 !== 3'd0) begin
        n_errors++;
        $display("FAIL areset_stale cycle %0d: got v=%b out=%b inf0=%0d, expected v=0 out=00 inf0=0",
                 c, o_out_valid, o_out, o_inflight0);
      end
      next_cycle();
    end
    i_req0 = 1'b1;
    #1;
    n_checks++;
    if (o_gnt0 !== 1'b1) begin
      n_errors++;
      $display("FAIL areset_regrant: got g0=%b, expected 1", o_gnt0);
    end
    next_cycle();
    i_req0 = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    i_flush = 1'b0; i_req0 = 1'b0; i_req1 = 1'b0; i_in0 = 2'b00; i_in1 = 2'b00;
    test_reset();
    test_latency_sanitise();
    test_burst_rr();
    test_single_requester();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
